// File: rtl/tgate_pkg.sv
// Shared definitions for the transmission-gate shift sequencer.
package tgate_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        GAP1 = 3'd2,
        PH2  = 3'd3,
        GAP2 = 3'd4,
        DONE = 3'd5
    } state_e;

    // Gate control levels: nMOS conducts on 1, pMOS conducts on 0.
    localparam logic GATE_ON_N  = 1'b1;
    localparam logic GATE_ON_P  = 1'b0;
    localparam logic GATE_OFF_N = 1'b0;
    localparam logic GATE_OFF_P = 1'b1;

    // States during which a shift sequence is in progress.
    function automatic logic is_busy(input state_e s);
        return (s == PH1) || (s == GAP1) || (s == PH2) || (s == GAP2);
    endfunction

endpackage

// File: rtl/tgate_pair_drv.sv
// Registered complementary control pair for one transmission gate.
module tgate_pair_drv
    import tgate_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_d,
    output logic ncontrol,
    output logic pcontrol
);

    logic ncontrol_d, pcontrol_d;
    logic ncontrol_q, pcontrol_q;

    // Both levels derive from one enable, so they can never disagree.
    always_comb begin
        ncontrol_d = en_d ? GATE_ON_N : GATE_OFF_N;
        pcontrol_d = en_d ? GATE_ON_P : GATE_OFF_P;
    end

    // Register the pair; reset turns the gate off.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncontrol_q <= GATE_OFF_N;
            pcontrol_q <= GATE_OFF_P;
        end else begin
            ncontrol_q <= ncontrol_d;
            pcontrol_q <= pcontrol_d;
        end
    end

    assign ncontrol = ncontrol_q;
    assign pcontrol = pcontrol_q;

endmodule

// File: rtl/tgate_shift_ctrl.sv
// Two-phase non-overlapping sequencer driving a transmission-gate shift
// chain, with a shadow register mirroring the chain contents.
module tgate_shift_ctrl
    import tgate_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PHASE_CYC = 2,
    parameter int DEAD_CYC  = 1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] nbits,
    input  logic             din,
    output logic             p1_ncontrol,
    output logic             p1_pcontrol,
    output logic             p2_ncontrol,
    output logic             p2_pcontrol,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int TMR_MAX = (PHASE_CYC > DEAD_CYC) ? PHASE_CYC : DEAD_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] PH_LAST   = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WIDTH);

    state_e             state_d, state_q;
    logic [TMR_W-1:0]   tmr_d, tmr_q;
    logic [CNT_W-1:0]   bits_d, bits_q;
    logic               bit_d, bit_q;
    logic [WIDTH-1:0]   shreg_d, shreg_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic [CNT_W-1:0]   nbits_sat;
    logic               p1_en_d, p2_en_d;

    assign nbits_sat = (nbits > CNT_SAT) ? CNT_SAT : nbits;

    // Next-state logic: phase/dead timing, bit counting and shadow shift.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        bits_d  = bits_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;

        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (start) begin
                    bits_d = nbits_sat;
                    if (nbits_sat == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = PH1;
                        bit_d   = din;
                    end
                end
            end
            PH1: begin
                if (tmr_q == PH_LAST) begin
                    state_d = GAP1;
                    tmr_d   = '0;
                end
            end
            GAP1: begin
                if (tmr_q == DEAD_LAST) begin
                    state_d = PH2;
                    tmr_d   = '0;
                end
            end
            PH2: begin
                if (tmr_q == PH_LAST) begin
                    state_d = GAP2;
                    tmr_d   = '0;
                    shreg_d = {shreg_q[WIDTH-2:0], bit_q};
                    bits_d  = bits_q - 1'b1;
                end
            end
            GAP2: begin
                if (tmr_q == DEAD_LAST) begin
                    tmr_d = '0;
                    if (bits_q != '0) begin
                        state_d = PH1;
                        bit_d   = din;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        // Abort overrides the shift on the last PH2 cycle, so a partial bit
        // never reaches the shadow register.
        if (abort && is_busy(state_q)) begin
            state_d = IDLE;
            tmr_d   = '0;
            bits_d  = '0;
            shreg_d = shreg_q;
        end

        busy_d  = is_busy(state_d);
        done_d  = (state_d == DONE);
        p1_en_d = (state_d == PH1);
        p2_en_d = (state_d == PH2);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bits_q  <= '0;
            bit_q   <= 1'b0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bits_q  <= bits_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tgate_pair_drv u_p1_drv (
        .clk      (clk),
        .rst      (rst),
        .en_d     (p1_en_d),
        .ncontrol (p1_ncontrol),
        .pcontrol (p1_pcontrol)
    );

    tgate_pair_drv u_p2_drv (
        .clk      (clk),
        .rst      (rst),
        .en_d     (p2_en_d),
        .ncontrol (p2_ncontrol),
        .pcontrol (p2_pcontrol)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign q    = shreg_q;

endmodule

// File: tb/tb_tgate_shift_ctrl.sv
// Self-checking bench for tgate_shift_ctrl using a cycle-arithmetic model.
module tb_tgate_shift_ctrl;

    localparam int WIDTH     = 8;
    localparam int PHASE_CYC = 2;
    localparam int DEAD_CYC  = 1;
    localparam int CNT_W     = $clog2(WIDTH + 1);
    localparam int T         = 2 * (PHASE_CYC + DEAD_CYC);
    localparam int VW        = WIDTH + 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] nbits;
    logic             din;
    logic             p1_ncontrol, p1_pcontrol, p2_ncontrol, p2_pcontrol;
    logic             busy, done;
    logic [WIDTH-1:0] q;

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] q_ref;

    always #5 clk = ~clk;

    tgate_shift_ctrl #(
        .WIDTH     (WIDTH),
        .PHASE_CYC (PHASE_CYC),
        .DEAD_CYC  (DEAD_CYC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .nbits       (nbits),
        .din         (din),
        .p1_ncontrol (p1_ncontrol),
        .p1_pcontrol (p1_pcontrol),
        .p2_ncontrol (p2_ncontrol),
        .p2_pcontrol (p2_pcontrol),
        .busy        (busy),
        .done        (done),
        .q           (q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector {p1n, p1p, p2n, p2p, busy, done, q}.
    function automatic logic [VW-1:0] exp_vec(input logic p1, input logic p2,
                                              input logic bz, input logic dn,
                                              input logic [WIDTH-1:0] qv);
        return {p1, ~p1, p2, ~p2, bz, dn, qv};
    endfunction

    // Shadow value seen in cycle c: bit i lands once its slave phase ends.
    function automatic logic [WIDTH-1:0] q_at(input int c, input int n,
                                              input logic [WIDTH-1:0] q0,
                                              input logic [WIDTH-1:0] pat);
        logic [WIDTH-1:0] r;
        r = q0;
        for (int i = 0; i < n; i++)
            if (i * T + 2 * PHASE_CYC + DEAD_CYC + 1 <= c)
                r = (r << 1) | WIDTH'(pat[i]);
        return r;
    endfunction

    task automatic check(input string tag, input int c, input logic [VW-1:0] expv);
        logic [VW-1:0] obs;
        logic [3:0]    g;
        obs = {p1_ncontrol, p1_pcontrol, p2_ncontrol, p2_pcontrol, busy, done, q};
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d outputs observed=%b expected=%b", tag, c, obs, expv);
        end
        g = {p1_ncontrol, p1_pcontrol, p2_ncontrol, p2_pcontrol};
        compared++;
        assert ((p1_pcontrol === ~p1_ncontrol) && (p2_pcontrol === ~p2_ncontrol)
                && !(p1_ncontrol && p2_ncontrol)) else begin
            mismatched++;
            $error("FAIL %s_gates cyc=%0d observed=%b expected=complementary,non-overlapping",
                   tag, c, g);
        end
    endtask

    // One sequence: ab_c / rst_c give the cycle (1-based after the start
    // edge) whose closing edge sees abort / rst; 0 means none.
    task automatic run_seq(input string tag, input int nb, input logic [WIDTH-1:0] pat,
                           input int ab_c, input int rst_c, input bit start_abort);
        int n;
        int stop_c;
        int o;
        logic [WIDTH-1:0] q0;
        logic [VW-1:0] e;
        n  = (nb > WIDTH) ? WIDTH : nb;
        q0 = q_ref;
        stop_c = n * T + 2;
        if (ab_c != 0)  stop_c = ab_c + 1;
        if (rst_c != 0) stop_c = rst_c + 1;

        start = 1'b1;
        nbits = CNT_W'(nb);
        abort = start_abort;
        din   = pat[0];
        tick();
        start = 1'b0;
        abort = 1'b0;

        for (int c = 1; c <= stop_c; c++) begin
            if (rst_c != 0 && c > rst_c)
                e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, '0);
            else if (ab_c != 0 && c > ab_c)
                e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, q_at(ab_c, n, q0, pat));
            else if (c <= n * T) begin
                o = (c - 1) % T;
                e = exp_vec(o < PHASE_CYC,
                            (o >= PHASE_CYC + DEAD_CYC) && (o < 2 * PHASE_CYC + DEAD_CYC),
                            1'b1, 1'b0, q_at(c, n, q0, pat));
            end else if (c == n * T + 1)
                e = exp_vec(1'b0, 1'b0, 1'b0, 1'b1, q_at(c, n, q0, pat));
            else
                e = exp_vec(1'b0, 1'b0, 1'b0, 1'b0, q_at(c, n, q0, pat));
            check(tag, c, e);

            din   = ((c % T == 0) && (c / T < n)) ? pat[c / T] : 1'($urandom);
            abort = (c == ab_c);
            rst   = (c == rst_c);
            if (c == n * T + 1 && ab_c == 0 && rst_c == 0) begin
                // start and abort in the DONE cycle must both be ignored
                start = 1'b1;
                abort = 1'($urandom);
            end
            if (c < stop_c) tick();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
        end

        if (rst_c != 0)     q_ref = '0;
        else if (ab_c != 0) q_ref = q_at(ab_c, n, q0, pat);
        else                q_ref = q_at(n * T + 1, n, q0, pat);
    endtask

    initial begin
        int nb;
        int ab;
        int nn;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        din   = 1'b0;
        nbits = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", i, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, '0));
        end
        rst = 1'b0;
        tick();
        check("reset_release", 0, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, '0));
        q_ref = '0;

        // three bits 1,0,1 -> 0x05, done in cycle 19
        run_seq("n3", 3, 8'b0000_0101, 0, 0, 1'b0);
        // zero bits: immediate done, q unchanged
        run_seq("n0", 0, 8'h00, 0, 0, 1'b0);
        // saturation: 12 requested, 8 shifted, all ones
        run_seq("n12", 12, 8'hFF, 0, 0, 1'b0);
        // reset during GAP1 of the first bit
        run_seq("rst_gap1", 4, 8'hFF, 0, PHASE_CYC + 1, 1'b0);
        // start with abort in IDLE, then abort on the last PH2 cycle of bit 2
        run_seq("abort_ph2", 4, 8'hFF, T + 2 * PHASE_CYC + DEAD_CYC, 0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            nb = $urandom_range(0, 12);
            nn = (nb > WIDTH) ? WIDTH : nb;
            ab = 0;
            if (nn > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, nn * T);
            run_seq("rand", nb, 8'($urandom), ab, 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
